disp_scan_mux: RTL and testbench



---
 rtl/disp_pkg.sv | 39 +++
 rtl/disp_scan_mux_if.sv | 27 ++
 rtl/disp_seg_decode.sv | 12 +
 rtl/disp_scan_mux.sv | 115 +++++++++++
 tb/tb_disp_scan_mux.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - segment width, 14-segment digit patterns and BCD decode
// Bit map (active-low): [0]a [1]b [2]c [3]d [4]e [5]f [6]g1 [7]g2
// [8]h [9]i [10]j [11]k [12]l [13]m [14]dp
package disp_pkg;

    localparam int SEG_W = 15;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_DARK = 15'h7FFF;
    localparam seg_t SEG_0    = ~15'h003F;
    localparam seg_t SEG_1    = ~15'h0006;
    localparam seg_t SEG_2    = ~15'h00DB;
    localparam seg_t SEG_3    = ~15'h00CF;
    localparam seg_t SEG_4    = ~15'h00E6;
    localparam seg_t SEG_5    = ~15'h00ED;
    localparam seg_t SEG_6    = ~15'h00FD;
    localparam seg_t SEG_7    = ~15'h0007;
    localparam seg_t SEG_8    = ~15'h00FF;
    localparam seg_t SEG_9    = ~15'h00EF;

    // Codes 10..15 are not digits and render dark.
    function automatic seg_t bcd_to_seg(input logic [3:0] code);
        case (code)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_DARK;
        endcase
    endfunction

endpackage

// File: rtl/disp_scan_mux_if.sv
// rtl/disp_scan_mux_if.sv - value/control inputs and pin outputs of the scan mux
// master: drives digit, blank_lz, blink_mask, brightness; receives seg, an, frame_start
// slave : the scan mux itself
interface disp_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    import disp_pkg::*;

    logic [4*NUM_DIGITS-1:0] digit;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [2:0]              brightness;
    seg_t                    seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_start;

    modport master (
        output digit, blank_lz, blink_mask, brightness,
        input  seg, an, frame_start
    );

    modport slave (
        input  digit, blank_lz, blink_mask, brightness,
        output seg, an, frame_start
    );

endinterface

// File: rtl/disp_seg_decode.sv
// rtl/disp_seg_decode.sv - combinational BCD code to active-low 15-bit pattern
// i_code: 4-bit code; o_seg: pattern, all ones for codes 10..15
module disp_seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] i_code,
    output seg_t       o_seg
);

    assign o_seg = bcd_to_seg(i_code);

endmodule

// File: rtl/disp_scan_mux.sv
// rtl/disp_scan_mux.sv - time-multiplexed 14-segment+dp digit driver
// clk, rst (sync, active-high); bus (slave): digit/blank_lz/blink_mask/brightness in,
// seg/an (active-low, registered) and frame_start pulse out.
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 16384,
    parameter int GUARD_CYC    = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic            clk,
    input  logic            rst,
    disp_scan_mux_if.slave  bus
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int SEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W  = $clog2(BLINK_FRAMES + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_TOP   = FRM_W'(BLINK_FRAMES);
    localparam logic [SLOT_W-1:0] GUARD     = SLOT_W'(GUARD_CYC);

    logic [SLOT_W-1:0]     r_slot;
    logic [SEL_W-1:0]      r_sel;
    logic [FRM_W-1:0]      r_frame_cnt;
    logic                  r_blink_phase;
    logic [3:0]            r_snap_digit [NUM_DIGITS];
    logic                  r_snap_blank;
    logic [NUM_DIGITS-1:0] r_snap_blink;
    seg_t                  r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_start;

    logic                  w_snap;
    logic [NUM_DIGITS-1:0] w_lz_dark;
    logic [3:0]            w_bright_p1;
    logic [SLOT_W:0]       w_limit;
    logic                  w_active;
    logic                  w_dark;
    seg_t                  w_pat;
    seg_t                  w_seg_next;
    logic [NUM_DIGITS-1:0] w_an_next;

    assign w_snap = (r_sel == '0) && (r_slot == '0);

    // Leading-zero blanking: walk from the top digit down while every digit seen is zero.
    always_comb begin : lz_blk
        logic zero_above;
        zero_above = 1'b1;
        w_lz_dark  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above & (r_snap_digit[i] == 4'd0);
            w_lz_dark[i] = r_snap_blank & zero_above & (i != 0);
        end
    end

    // Window end = (brightness+1) * REFRESH_DIV/8; REFRESH_DIV is a power of two, so a shift.
    assign w_bright_p1 = {1'b0, bus.brightness} + 4'd1;
    assign w_limit     = {{(SLOT_W-3){1'b0}}, w_bright_p1} << (SLOT_W - 3);
    assign w_active    = (r_slot >= GUARD) && ({1'b0, r_slot} < w_limit);

    assign w_dark = w_lz_dark[r_sel] | (r_blink_phase & r_snap_blink[r_sel]);

    disp_seg_decode u_decode (
        .i_code (r_snap_digit[r_sel]),
        .o_seg  (w_pat)
    );

    assign w_an_next  = w_active ? ~(NUM_DIGITS'(1) << r_sel) : '1;
    assign w_seg_next = (w_active && !w_dark) ? w_pat : SEG_DARK;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot        <= '0;
            r_sel         <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_snap_digit[i] <= 4'hF;
            r_snap_blank  <= 1'b0;
            r_snap_blink  <= '0;
            r_seg         <= SEG_DARK;
            r_an          <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
            if (r_slot == SLOT_LAST) begin
                r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
            end
            r_frame_start <= w_snap;
            if (w_snap) begin
                for (int i = 0; i < NUM_DIGITS; i++) r_snap_digit[i] <= bus.digit[4*i +: 4];
                r_snap_blank <= bus.blank_lz;
                r_snap_blink <= bus.blink_mask;
                // Counter runs 1..BLINK_FRAMES after the first frame, so the phase
                // holds for exactly BLINK_FRAMES frames including the very first.
                if (r_frame_cnt == FRM_TOP) begin
                    r_frame_cnt   <= FRM_W'(1);
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign bus.seg         = r_seg;
    assign bus.an          = r_an;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_disp_scan_mux.sv
// tb/tb_disp_scan_mux.sv - self-checking bench for disp_scan_mux
module tb_disp_scan_mux;

    localparam int N  = 4;
    localparam int RD = 16;
    localparam int G  = 1;
    localparam int BF = 2;
    localparam int FR = N * RD;

    localparam logic [14:0] PAT_ON [10] = '{15'h003F, 15'h0006, 15'h00DB, 15'h00CF, 15'h00E6,
                                             15'h00ED, 15'h00FD, 15'h0007, 15'h00FF, 15'h00EF};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    disp_scan_mux_if #(.NUM_DIGITS(N)) bus ();

    disp_scan_mux #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RD),
        .GUARD_CYC    (G),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] exp_pat(input logic [3:0] code);
        if (code < 4'd10) return ~PAT_ON[code];
        return 15'h7FFF;
    endfunction

    // Reference model: m_c is cycles since reset release; outputs after posedge
    // for cycle c are derived from slot/digit/frame arithmetic on c.
    int          m_c = 0;
    logic        m_valid = 1'b0;
    logic [3:0]  m_snap [N];
    logic        m_blank;
    logic [N-1:0] m_mask;
    logic [N-1:0] e_an;
    logic [14:0] e_seg;
    logic        e_fs;

    always @(posedge clk) begin : model
        int slot, sel, lim, hi;
        logic [1:0] s2;
        logic dark;
        if (rst) begin
            m_valid = 1'b1;
            m_c     = 0;
            e_an    = '1;
            e_seg   = 15'h7FFF;
            e_fs    = 1'b0;
            for (int j = 0; j < N; j++) m_snap[j] = 4'hF;
            m_blank = 1'b0;
            m_mask  = '0;
        end else if (m_valid) begin
            slot = m_c % RD;
            sel  = (m_c / RD) % N;
            s2   = 2'(sel);
            lim  = (int'(bus.brightness) + 1) * RD / 8;
            hi   = -1;
            for (int j = 0; j < N; j++) if (m_snap[j] != 4'd0) hi = j;
            dark = (m_blank && sel >= 1 && sel > hi) ||
                   (m_mask[s2] && (((m_c / FR) / BF) % 2 == 1));
            if (slot >= G && slot < lim) begin
                e_an  = ~(4'b0001 << sel);
                e_seg = dark ? 15'h7FFF : exp_pat(m_snap[s2]);
            end else begin
                e_an  = '1;
                e_seg = 15'h7FFF;
            end
            e_fs = (m_c % FR == 0);
            if (m_c % FR == 0) begin
                for (int j = 0; j < N; j++) m_snap[j] = bus.digit[4*j +: 4];
                m_blank = bus.blank_lz;
                m_mask  = bus.blink_mask;
            end
            m_c++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_an", 32'(bus.an), 32'(e_an));
            chk("model_seg", 32'(bus.seg), 32'(e_seg));
            chk("model_fs", 32'(bus.frame_start), 32'(e_fs));
        end
    end

    task automatic wait_c(input int tgt);
        for (int i = 0; i < 4 * FR; i++) begin
            @(negedge clk);
            if (m_c % FR == tgt) return;
        end
        chk("wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic count_lit(input int cycles, output int lit, output int on);
        lit = 0;
        on  = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.an != 4'hF) on++;
            if (bus.an != 4'hF && bus.seg != 15'h7FFF) lit++;
        end
    endtask

    initial begin
        int n_sel0, n_fs, lit, on, n5, n0;
        bus.digit      = 16'h4321;
        bus.blank_lz   = 1'b0;
        bus.blink_mask = '0;
        bus.brightness = 3'd7;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_seg", 32'(bus.seg), 32'h7FFF);
        chk("rst_fs", 32'(bus.frame_start), 32'h0);
        rst = 1'b0;

        // Plain scan of 4321 at full brightness
        n_sel0 = 0;
        n_fs   = 0;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            if (bus.frame_start) n_fs++;
            if (k <= 64 && bus.an == 4'b1110) n_sel0++;
            if (k == 1)  chk("fs_first", 32'(bus.frame_start), 32'h1);
            if (k == 2)  begin chk("scan_an0", 32'(bus.an), 32'hE); chk("scan_seg1", 32'(bus.seg), 32'h7FF9); end
            if (k == 17) chk("scan_guard", 32'(bus.an), 32'hF);
            if (k == 18) begin chk("scan_an1", 32'(bus.an), 32'hD); chk("scan_seg2", 32'(bus.seg), 32'h7F24); end
            if (k == 34) begin chk("scan_an2", 32'(bus.an), 32'hB); chk("scan_seg3", 32'(bus.seg), 32'h7F30); end
            if (k == 50) begin chk("scan_an3", 32'(bus.an), 32'h7); chk("scan_seg4", 32'(bus.seg), 32'h7F19); end
            if (k == 65) chk("fs_period", 32'(bus.frame_start), 32'h1);
        end
        chk("sel0_cycles", 32'(n_sel0), 32'd15);
        chk("fs_count", 32'(n_fs), 32'd3);

        // Snapshot coherence
        bus.digit = 16'h1111;
        wait_c(1);
        wait_c(37);
        bus.digit = 16'h2222;
        wait_c(54);
        chk("coh_old_an", 32'(bus.an), 32'h7);
        chk("coh_old_seg", 32'(bus.seg), 32'h7FF9);
        wait_c(6);
        chk("coh_new_an", 32'(bus.an), 32'hE);
        chk("coh_new_seg", 32'(bus.seg), 32'h7F24);

        // Brightness windows
        bus.brightness = 3'd0;
        repeat (70) @(negedge clk);
        count_lit(64, lit, on);
        chk("bright0_on", 32'(on), 32'd4);
        bus.brightness = 3'd3;
        repeat (70) @(negedge clk);
        count_lit(64, lit, on);
        chk("bright3_on", 32'(on), 32'd28);
        bus.brightness = 3'd7;

        // Leading-zero blanking
        bus.digit    = 16'h0050;
        bus.blank_lz = 1'b1;
        repeat (130) @(negedge clk);
        n5 = 0;
        n0 = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.seg == 15'h7F12) n5++;
            if (bus.seg == 15'h7FC0) n0++;
        end
        chk("lz_five", 32'(n5), 32'd15);
        chk("lz_zero", 32'(n0), 32'd15);
        bus.digit = 16'h0000;
        repeat (130) @(negedge clk);
        count_lit(64, lit, on);
        chk("lz_all_zero_lit", 32'(lit), 32'd15);
        chk("lz_all_zero_on", 32'(on), 32'd60);

        // Blink on digit 1
        bus.blank_lz   = 1'b0;
        bus.digit      = 16'h1111;
        bus.blink_mask = 4'b0010;
        repeat (130) @(negedge clk);
        count_lit(256, lit, on);
        chk("blink_lit", 32'(lit), 32'd210);

        // Mid-frame reset pulse
        wait_c(40);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_an", 32'(bus.an), 32'hF);
        chk("mrst_seg", 32'(bus.seg), 32'h7FFF);
        chk("mrst_fs", 32'(bus.frame_start), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_fs_after", 32'(bus.frame_start), 32'h1);
        @(negedge clk);
        chk("mrst_an0", 32'(bus.an), 32'hE);
        chk("mrst_seg0", 32'(bus.seg), 32'h7FF9);

        // Randomised traffic against the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) bus.brightness = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) begin
                for (int j = 0; j < N; j++)
                    bus.digit[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                bus.blank_lz   = 1'($urandom_range(0, 1));
                bus.blink_mask = 4'($urandom_range(0, 15));
            end
        end
        rst = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
